// File: rtl/feature_collector.sv
// ============================================================================
// Module   : feature_collector
// Brief    : Show-ahead feature-address buffer with event/feature/drop stats.
// Revision : 1.0
// ============================================================================
`default_nettype none

module feature_collector #(
    parameter int ADDR_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int COUNT_WIDTH  = 32,
    parameter int DROP_ON_FULL = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_isfeature,
    input  logic [ADDR_WIDTH-1:0]         in_feature_addr,
    input  logic                          in_feature_valid,
    output logic                          ready_for_new_feature,
    output logic [ADDR_WIDTH-1:0]         out_feature_addr,
    output logic                          out_feature_valid,
    input  logic                          out_feature_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [COUNT_WIDTH-1:0]        event_count,
    output logic [COUNT_WIDTH-1:0]        feature_count,
    output logic [COUNT_WIDTH-1:0]        drop_count,
    output logic                          overflow,
    input  logic                          clear_stats
);

    localparam int                     PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]         C_DEPTH   = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]       C_PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]         C_FILL_ONE = (PTR_W+1)'(1);
    localparam logic [COUNT_WIDTH-1:0] C_CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] C_CNT_ONE = COUNT_WIDTH'(1);

    logic [ADDR_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W:0]         r_fill;
    logic [COUNT_WIDTH-1:0] r_event_cnt;
    logic [COUNT_WIDTH-1:0] r_feature_cnt;
    logic [COUNT_WIDTH-1:0] r_drop_cnt;
    logic                   r_overflow;

    logic w_full;
    logic w_empty;
    logic w_ready;
    logic w_accept;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_fill == C_DEPTH);
    assign w_empty = (r_fill == '0);
    assign w_ready = (DROP_ON_FULL != 0) ? 1'b1 : !w_full;

    assign w_accept = in_feature_valid && w_ready;
    assign w_pop    = !w_empty && out_feature_ready;
    // A full buffer can still take a feature when the head leaves on the same edge.
    assign w_push   = w_accept && in_isfeature && (!w_full || w_pop);
    assign w_drop   = w_accept && in_isfeature && w_full && !w_pop;

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= in_feature_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + C_FILL_ONE;
                2'b01:   r_fill <= r_fill - C_FILL_ONE;
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_event_cnt   <= '0;
            r_feature_cnt <= '0;
            r_drop_cnt    <= '0;
            r_overflow    <= 1'b0;
        end else if (clear_stats) begin
            r_event_cnt   <= '0;
            r_feature_cnt <= '0;
            r_drop_cnt    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_accept && (r_event_cnt != C_CNT_MAX)) begin
                r_event_cnt <= r_event_cnt + C_CNT_ONE;
            end
            if (w_push && (r_feature_cnt != C_CNT_MAX)) begin
                r_feature_cnt <= r_feature_cnt + C_CNT_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != C_CNT_MAX) begin
                    r_drop_cnt <= r_drop_cnt + C_CNT_ONE;
                end
            end
        end
    end

    assign ready_for_new_feature = w_ready;
    assign out_feature_valid     = !w_empty;
    assign out_feature_addr      = r_mem[r_rd_ptr];
    assign fill_level            = r_fill;
    assign event_count           = r_event_cnt;
    assign feature_count         = r_feature_cnt;
    assign drop_count            = r_drop_cnt;
    assign overflow              = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_feature_collector.sv
// ============================================================================
// Module   : tb_feature_collector
// Brief    : Scoreboard bench: back-pressure, drop-on-full and saturating instances.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_feature_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic        isf   [3];
    logic [15:0] addr  [3];
    logic        vld   [3];
    logic        ordy  [3];
    logic        clr   [3];
    logic        rdy   [3];
    logic [15:0] oaddr [3];
    logic        ovld  [3];
    logic        ovf   [3];

    logic [4:0]  fl0, fl1;
    logic [2:0]  fl2;
    logic [31:0] ec0, ec1, fc0, fc1, dc0, dc1;
    logic [2:0]  ec2, fc2, dc2;

    feature_collector #(.ADDR_WIDTH(16), .FIFO_DEPTH(16), .COUNT_WIDTH(32), .DROP_ON_FULL(0)) u_bp (
        .clk(clk), .rst_n(rst_n[0]), .in_isfeature(isf[0]), .in_feature_addr(addr[0]),
        .in_feature_valid(vld[0]), .ready_for_new_feature(rdy[0]), .out_feature_addr(oaddr[0]),
        .out_feature_valid(ovld[0]), .out_feature_ready(ordy[0]), .fill_level(fl0),
        .event_count(ec0), .feature_count(fc0), .drop_count(dc0), .overflow(ovf[0]),
        .clear_stats(clr[0]));

    feature_collector #(.ADDR_WIDTH(16), .FIFO_DEPTH(16), .COUNT_WIDTH(32), .DROP_ON_FULL(1)) u_dr (
        .clk(clk), .rst_n(rst_n[1]), .in_isfeature(isf[1]), .in_feature_addr(addr[1]),
        .in_feature_valid(vld[1]), .ready_for_new_feature(rdy[1]), .out_feature_addr(oaddr[1]),
        .out_feature_valid(ovld[1]), .out_feature_ready(ordy[1]), .fill_level(fl1),
        .event_count(ec1), .feature_count(fc1), .drop_count(dc1), .overflow(ovf[1]),
        .clear_stats(clr[1]));

    feature_collector #(.ADDR_WIDTH(16), .FIFO_DEPTH(4), .COUNT_WIDTH(3), .DROP_ON_FULL(1)) u_sat (
        .clk(clk), .rst_n(rst_n[2]), .in_isfeature(isf[2]), .in_feature_addr(addr[2]),
        .in_feature_valid(vld[2]), .ready_for_new_feature(rdy[2]), .out_feature_addr(oaddr[2]),
        .out_feature_valid(ovld[2]), .out_feature_ready(ordy[2]), .fill_level(fl2),
        .event_count(ec2), .feature_count(fc2), .drop_count(dc2), .overflow(ovf[2]),
        .clear_stats(clr[2]));

    // Reference model
    int     depth  [3] = '{16, 16, 4};
    bit     dropm  [3] = '{1'b0, 1'b1, 1'b1};
    longint cmax   [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd7};
    int     m_fill [3];
    longint m_ev [3], m_ft [3], m_dr [3];
    bit     m_ovf [3];
    logic [15:0] q0 [$], q1 [$], q2 [$];

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [31:0] obs_fill(int i);
        case (i)
            0:       return {27'd0, fl0};
            1:       return {27'd0, fl1};
            default: return {29'd0, fl2};
        endcase
    endfunction

    function automatic logic [31:0] obs_ec(int i);
        case (i)
            0:       return ec0;
            1:       return ec1;
            default: return {29'd0, ec2};
        endcase
    endfunction

    function automatic logic [31:0] obs_fc(int i);
        case (i)
            0:       return fc0;
            1:       return fc1;
            default: return {29'd0, fc2};
        endcase
    endfunction

    function automatic logic [31:0] obs_dc(int i);
        case (i)
            0:       return dc0;
            1:       return dc1;
            default: return {29'd0, dc2};
        endcase
    endfunction

    function automatic logic [15:0] q_front(int i);
        case (i)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void q_pop(int i);
        case (i)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void q_push(int i, logic [15:0] a);
        case (i)
            0:       q0.push_back(a);
            1:       q1.push_back(a);
            default: q2.push_back(a);
        endcase
    endfunction

    function automatic void model_reset(int i);
        m_fill[i] = 0; m_ev[i] = 0; m_ft[i] = 0; m_dr[i] = 0; m_ovf[i] = 1'b0;
        case (i)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] o, logic [31:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    task automatic check_state(int i, string tag);
        check({tag, ".fill"},   obs_fill(i), 32'(m_fill[i]));
        check({tag, ".valid"},  {31'd0, ovld[i]}, {31'd0, m_fill[i] != 0});
        check({tag, ".events"}, obs_ec(i), 32'(m_ev[i]));
        check({tag, ".feats"},  obs_fc(i), 32'(m_ft[i]));
        check({tag, ".drops"},  obs_dc(i), 32'(m_dr[i]));
        check({tag, ".ovf"},    {31'd0, ovf[i]}, {31'd0, m_ovf[i]});
        if (m_fill[i] != 0) check({tag, ".head"}, {16'd0, oaddr[i]}, {16'd0, q_front(i)});
    endtask

    task automatic check_reset(int i, string tag);
        check({tag, ".valid"}, {31'd0, ovld[i]}, 32'd0);
        check({tag, ".addr"},  {16'd0, oaddr[i]}, 32'd0);
        check({tag, ".fill"},  obs_fill(i), 32'd0);
        check({tag, ".ready"}, {31'd0, rdy[i]}, 32'd1);
        check({tag, ".cnt"},   obs_ec(i) | obs_fc(i) | obs_dc(i), 32'd0);
        check({tag, ".ovf"},   {31'd0, ovf[i]}, 32'd0);
    endtask

    // One clock of stimulus on instance i; called just after a rising edge.
    task automatic step(int i, bit v, bit f, logic [15:0] a, bit r, bit c, string tag);
        bit rm, pop, acc, push, drp;
        vld[i] = v; isf[i] = f; addr[i] = a; ordy[i] = r; clr[i] = c;
        #1;
        rm = dropm[i] ? 1'b1 : (m_fill[i] != depth[i]);
        check({tag, ".ready"}, {31'd0, rdy[i]}, {31'd0, rm});
        pop  = (m_fill[i] != 0) && r;
        acc  = v && rm;
        push = acc && f && ((m_fill[i] != depth[i]) || pop);
        drp  = acc && f && !push;
        @(posedge clk);
        #1;
        vld[i] = 1'b0; ordy[i] = 1'b0; clr[i] = 1'b0;
        if (pop)  q_pop(i);
        if (push) q_push(i, a);
        m_fill[i] = m_fill[i] + int'(push) - int'(pop);
        if (c) begin
            m_ev[i] = 0; m_ft[i] = 0; m_dr[i] = 0; m_ovf[i] = 1'b0;
        end else begin
            if (acc  && m_ev[i] < cmax[i]) m_ev[i]++;
            if (push && m_ft[i] < cmax[i]) m_ft[i]++;
            if (drp) begin
                m_ovf[i] = 1'b1;
                if (m_dr[i] < cmax[i]) m_dr[i]++;
            end
        end
        check_state(i, tag);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; isf[i] = 1'b0; addr[i] = '0; vld[i] = 1'b0;
            ordy[i] = 1'b0; clr[i] = 1'b0;
            model_reset(i);
        end
        // Inputs presented during reset must be ignored.
        vld[0] = 1'b1; isf[0] = 1'b1; addr[0] = 16'hAAAA;
        #12;
        for (int i = 0; i < 3; i++) check_reset(i, "rst");
        @(posedge clk);
        #1;
        check_reset(0, "rst_hold");
        vld[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(posedge clk);
        #1;

        // Mixed feature / non-feature events, then two pops in order.
        step(0, 1, 1, 16'h0102, 0, 0, "mix0");
        step(0, 1, 0, 16'h0203, 0, 0, "mix1");
        step(0, 1, 1, 16'h0304, 0, 0, "mix2");
        step(0, 0, 0, 16'h0000, 1, 0, "mix_pop0");
        step(0, 0, 0, 16'h0000, 1, 0, "mix_pop1");
        step(0, 0, 0, 16'h0000, 1, 0, "pop_empty");

        // Back-pressure: 17th feature held until a pop frees a slot.
        for (int k = 0; k < 17; k++) step(0, 1, 1, 16'h1000 + 16'(k), 0, 0, "bp_fill");
        step(0, 1, 1, 16'h1010, 1, 0, "bp_pop_full");
        step(0, 1, 1, 16'h1010, 0, 0, "bp_retry");
        for (int k = 0; k < 16; k++) step(0, 0, 0, 16'h0000, 1, 0, "bp_drain");

        // Clear on the same edge as an accepted feature.
        step(0, 1, 1, 16'h5A5A, 0, 1, "clr_push");
        for (int k = 0; k < 4; k++) step(0, 1, 1, 16'h2000 + 16'(k), 0, 0, "pre_rst");

        // Asynchronous reset between edges with five entries held.
        #2;
        rst_n[0] = 1'b0;
        #1;
        model_reset(0);
        check_reset(0, "async_rst");
        vld[0] = 1'b1; isf[0] = 1'b1; addr[0] = 16'h7777;
        @(posedge clk);
        #1;
        check_reset(0, "rst_ignore");
        #3;
        rst_n[0] = 1'b1;
        step(0, 1, 1, 16'h3131, 0, 0, "post_rst");

        // Drop on full, then clear while dropping, then full push+pop.
        for (int k = 0; k < 18; k++) step(1, 1, 1, 16'h4000 + 16'(k), 0, 0, "dr_fill");
        check("dr_fill.drops2", obs_dc(1), 32'd2);
        step(1, 1, 0, 16'h0000, 0, 0, "dr_nonfeat");
        step(1, 1, 1, 16'h4100, 1, 0, "dr_full_pushpop");
        step(1, 1, 1, 16'h4101, 0, 1, "dr_clr_drop");
        for (int k = 0; k < 16; k++) step(1, 0, 0, 16'h0000, 1, 0, "dr_drain");

        // Small instance: counter saturation and pointer wrap-around.
        for (int k = 0; k < 12; k++) step(2, 1, 1, 16'h6000 + 16'(k), 0, 0, "sat_fill");
        for (int k = 0; k < 10; k++) step(2, 1, 1, 16'h6100 + 16'(k), 1, 0, "sat_wrap");
        for (int k = 0; k < 5; k++)  step(2, 0, 0, 16'h0000, 1, 0, "sat_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
